// File: rtl/div_pkg.sv
// div_pkg: shared types for the divider family (reconstructor FSM states).
package div_pkg;
    typedef enum logic [1:0] {IDLE, MULT, FIX} recon_state_t;
endpackage

// File: rtl/dividend_reconstructor_if.sv
// dividend_reconstructor_if: Start/Done request bus carrying Coc, Den, Res in and Num out.
interface dividend_reconstructor_if #(parameter int tamanyo = 16);
    logic                   Start;
    logic [tamanyo-1:0]     Coc;
    logic [tamanyo-1:0]     Den;
    logic [tamanyo-1:0]     Res;
    logic [2*tamanyo-1:0]   Num;
    logic                   Done;
    logic                   Ready;
    modport master (output Start, Coc, Den, Res, input Num, Done, Ready);
    modport slave  (input Start, Coc, Den, Res, output Num, Done, Ready);
endinterface

// File: rtl/dividend_reconstructor_signed_abs.sv
// signed_abs: two's-complement magnitude and sign; -2^(n-1) maps to 2^(n-1) unsigned.
module signed_abs #(parameter int tamanyo = 16) (
    input  logic [tamanyo-1:0] val,
    output logic [tamanyo-1:0] mag,
    output logic               neg
);
    assign neg = val[tamanyo-1];
    assign mag = neg ? -val : val;
endmodule

// File: rtl/dividend_reconstructor.sv
// dividend_reconstructor: sequential Num = Coc*Den + Res via radix-2 shift-add on magnitudes.
module dividend_reconstructor import div_pkg::*; #(parameter int tamanyo = 16) (
    input  logic CLK,
    input  logic RSTa,
    dividend_reconstructor_if.slave bus
);
    localparam int CW = $clog2(tamanyo + 1);
    localparam int W  = 2 * tamanyo;
    recon_state_t       state, state_nx;
    logic [W-1:0]       mcand, acc, res_ext, num;
    logic [tamanyo-1:0] mplier, coc_mag, den_mag;
    logic [CW-1:0]      cnt;
    logic               sign, done, coc_neg, den_neg;
    signed_abs #(.tamanyo(tamanyo)) u_coc (.val(bus.Coc), .mag(coc_mag), .neg(coc_neg));
    signed_abs #(.tamanyo(tamanyo)) u_den (.val(bus.Den), .mag(den_mag), .neg(den_neg));
    assign bus.Num  = num;
    assign bus.Done = done;
    assign bus.Ready = (state == IDLE);
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (bus.Start ? MULT : IDLE) :
                   (state == MULT) ? ((cnt == CW'(tamanyo - 1)) ? FIX : MULT) : IDLE;
    end
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            res_ext <= '0;
            sign    <= 1'b0;
            cnt     <= '0;
            num     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.Start) begin
                    mcand   <= {{tamanyo{1'b0}}, den_mag};
                    mplier  <= coc_mag;
                    sign    <= coc_neg ^ den_neg;
                    res_ext <= {{tamanyo{bus.Res[tamanyo-1]}}, bus.Res};
                    acc     <= '0;
                    cnt     <= '0;
                end
                MULT: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                FIX: begin
                    // Wraps modulo 2^W; the product magnitude leaves headroom for Res.
                    num  <= (sign ? -acc : acc) + res_ext;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
